collision_scan_ctrl: RTL and testbench
======================================

// Module: collision_scan_ctrl
// PURPOSE
//  Sequencer that owns the car position table and shares one overlap checker across all cars.
//  A move request carries a car index and a proposed position/orientation.
//  The block scans every other valid car, one per clock, and reports collision / hit index.
//  On a clean move, it commits the new position to the table.
//  Sits between game input logic and the VGA renderer; replaces per-car parallel collision checkers.
// PARAMETERS
//  NUM_CARS   8    number of table entries; IDX_W = $clog2(NUM_CARS)
//  COORD_W    10   pixel coordinate width (x, y)
//  CAR_LONG   20   footprint long side, pixels
//  CAR_SHORT  10   footprint short side, pixels
//  FIELD_W    640  field width, pixels (used only with BOUNDS_CHECK_EN)
//  FIELD_H    480  field height, pixels (used only with BOUNDS_CHECK_EN)
// PORTS
//  clk            in   1        system clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  wr_en          in   1        load table entry (honoured in IDLE only)
//  wr_index       in   IDX_W    entry to load
//  wr_x, wr_y     in   COORD_W  entry position (top-left)
//  wr_orient      in   1        0 = horizontal (LONG x SHORT), 1 = vertical (SHORT x LONG)
//  req_valid      in   1        move request valid
//  req_ready      out  1        high in IDLE only
//  req_index      in   IDX_W    car being moved
//  req_x, req_y   in   COORD_W  proposed position
//  req_orient     in   1        proposed orientation
//  rsp_valid      out  1        one-cycle result pulse
//  rsp_collision  out  1        move rejected
//  rsp_hit_index  out  IDX_W    first colliding car (lowest index); 0 when no collision
//  rsp_wall       out  1        move rejected for leaving field
//  busy           out  1        high in SCAN and DONE
// BEHAVIOUR
//  Reset: state=IDLE; all entry valid bits=0; table contents are don't-care.
//    rsp_valid=0, rsp_collision=0, rsp_hit_index=0, rsp_wall=0, busy=0, req_ready=1 after deassert.
//  FSM IDLE -> SCAN -> DONE -> IDLE. Handshake: accept on req_valid & req_ready at a rising edge (E0).
//    The request is latched; SCAN starts with scan_idx = 0.
//  SCAN cycle i compares the latched footprint against entry i. Entries are skipped (no hit) when:
//    i == req_index, or entry i is not valid.
//  Overlap: ax < bx+bw && bx < ax+aw && ay < by+bh && by < ay+ah. Rectangles are half-open.
//    Sums use COORD_W+1 bits, so there is no wrap. Touching edges do not collide.
//  Early exit on first hit: DONE is entered at edge E(i+1).
//    With no hit, DONE is entered after entry NUM_CARS-1, so rsp_valid is high in the cycle after E(NUM_CARS).
//  DONE (one cycle): rsp_* valid.
//    If no collision and no wall hit: entry req_index <= latched x/y/orient, valid <= 1, at the DONE->IDLE edge.
//    rsp_* hold their values until the next DONE; only rsp_valid pulses.
//  wr_en in SCAN/DONE: silently dropped. wr_en and request accept on the same edge: write lands first.
//    The scan therefore sees the new entry.
//  req_index of a non-valid entry is legal: it places a new car if clear.
//  Reset mid-scan: immediate return to IDLE, no commit, no rsp_valid.
// CONFIGURATION
//  BOUNDS_CHECK_EN defined:
//    DONE also flags rsp_wall=1 when req_x+w > FIELD_W or req_y+h > FIELD_H.
//    A wall hit rejects the commit; rsp_collision is unaffected.
//  BOUNDS_CHECK_EN undefined: rsp_wall tied 0; FIELD_W/FIELD_H unused.
// STRUCTURE
//  Package collision_pkg: car_t {x, y, orient}; CAR_LONG/CAR_SHORT constants; scan state enum;
//    footprint width/height function of orient.
//  Sub-module car_overlap_check (combinational):
//    two car_t in, hit out; single instance driven by latched request and table[scan_idx].
// TESTING
//  1 Reset, then req car1 (10,20,0) with empty table -> rsp_valid after E8, collision=0; entry1 committed.
//  2 Load car0 (10,10,1); req car1 (10,20,0) -> rsp_valid after E1, collision=1, hit_index=0, entry1 unchanged.
//  3 Car0 as in 2; req car1 (20,20,0) -> touching edge x=20, collision=0, commit.
//  4 Cars 2 and 5 both overlapping the request -> hit_index=2, rsp_valid after E3.
//  5 wr_en during SCAN dropped; rst_n low mid-scan -> IDLE, no rsp_valid, all valid bits cleared.
//  6 BOUNDS_CHECK_EN: req (630,470,0) -> rsp_wall=1, no commit. Without the macro: rsp_wall=0, commit.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types for the collision scan sequencer: car record, scan states and footprint helpers.
package collision_pkg;

   localparam int COORD_W   = 10;
   localparam int CAR_LONG  = 20;
   localparam int CAR_SHORT = 10;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               orient;
   } car_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } scan_state_t;

   // Footprint extents are one bit wider than a coordinate so position + extent cannot wrap.
   function automatic logic [COORD_W:0] foot_w(input logic orient);
      return orient ? (COORD_W+1)'(CAR_SHORT) : (COORD_W+1)'(CAR_LONG);
   endfunction

   function automatic logic [COORD_W:0] foot_h(input logic orient);
      return orient ? (COORD_W+1)'(CAR_LONG) : (COORD_W+1)'(CAR_SHORT);
   endfunction

endpackage

// File: rtl/car_overlap_check.sv
// Combinational half-open rectangle overlap test between two car footprints; touching edges do not hit.
module car_overlap_check
   import collision_pkg::*;
(
   input  car_t i_car_a,
   input  car_t i_car_b,
   output logic o_hit
);

   logic [COORD_W:0] w_ax, w_ay, w_bx, w_by;
   logic [COORD_W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

   assign w_ax     = {1'b0, i_car_a.x};
   assign w_ay     = {1'b0, i_car_a.y};
   assign w_bx     = {1'b0, i_car_b.x};
   assign w_by     = {1'b0, i_car_b.y};
   assign w_ax_end = w_ax + foot_w(i_car_a.orient);
   assign w_ay_end = w_ay + foot_h(i_car_a.orient);
   assign w_bx_end = w_bx + foot_w(i_car_b.orient);
   assign w_by_end = w_by + foot_h(i_car_b.orient);

   assign o_hit = (w_ax < w_bx_end) && (w_bx < w_ax_end) &&
                  (w_ay < w_by_end) && (w_by < w_ay_end);

endmodule

// File: rtl/collision_scan_ctrl.sv
// Car position table plus a single shared overlap checker scanned one entry per clock.
// Optional field-boundary rejection is enabled by defining BOUNDS_CHECK_EN.
module collision_scan_ctrl
   import collision_pkg::*;
#(
   parameter  int NUM_CARS = 8,
   parameter  int FIELD_W  = 640,
   parameter  int FIELD_H  = 480,
   localparam int IDX_W    = $clog2(NUM_CARS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_index,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic               wr_orient,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [IDX_W-1:0]   req_index,
   input  logic [COORD_W-1:0] req_x,
   input  logic [COORD_W-1:0] req_y,
   input  logic               req_orient,
   output logic               rsp_valid,
   output logic               rsp_collision,
   output logic [IDX_W-1:0]   rsp_hit_index,
   output logic               rsp_wall,
   output logic               busy
);

   scan_state_t           r_state;
   logic [IDX_W-1:0]      r_scan_idx;
   logic [IDX_W-1:0]      r_req_index;
   car_t                  r_req;
   car_t                  r_table [NUM_CARS];
   logic [NUM_CARS-1:0]   r_valid;
   logic                  r_collision;
   logic [IDX_W-1:0]      r_hit_index;
   logic                  r_wall;

   logic                  w_overlap;
   logic                  w_hit;
   logic                  w_last;
   logic                  w_wall;
   logic                  w_table_wr;
   logic                  w_commit;

   car_overlap_check u_overlap (
      .i_car_a (r_req),
      .i_car_b (r_table[r_scan_idx]),
      .o_hit   (w_overlap)
   );

   assign w_hit      = w_overlap && r_valid[r_scan_idx] && (r_scan_idx != r_req_index);
   assign w_last     = (r_scan_idx == IDX_W'(NUM_CARS-1));
   assign w_table_wr = (r_state == ST_IDLE) && wr_en;
   assign w_commit   = (r_state == ST_DONE) && !r_collision && !r_wall;

`ifdef BOUNDS_CHECK_EN
   assign w_wall = (({1'b0, r_req.x} + foot_w(r_req.orient)) > (COORD_W+1)'(FIELD_W)) ||
                   (({1'b0, r_req.y} + foot_h(r_req.orient)) > (COORD_W+1)'(FIELD_H));
`else
   assign w_wall = 1'b0;
`endif

   // NOTE: the table array has no reset; only the valid bits define which entries are live.
   always_ff @(posedge clk) begin
      if (w_table_wr)
         r_table[wr_index] <= '{x: wr_x, y: wr_y, orient: wr_orient};
      else if (w_commit)
         r_table[r_req_index] <= r_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_scan_idx  <= '0;
         r_req_index <= '0;
         r_req       <= '0;
         r_valid     <= '0;
         r_collision <= 1'b0;
         r_hit_index <= '0;
         r_wall      <= 1'b0;
      end else begin
         if (w_table_wr)
            r_valid[wr_index] <= 1'b1;
         else if (w_commit)
            r_valid[r_req_index] <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_req       <= '{x: req_x, y: req_y, orient: req_orient};
                  r_req_index <= req_index;
                  r_scan_idx  <= '0;
                  r_state     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Early exit on the first hit keeps the lowest colliding index.
               if (w_hit || w_last) begin
                  r_collision <= w_hit;
                  r_hit_index <= w_hit ? r_scan_idx : '0;
                  r_wall      <= w_wall;
                  r_state     <= ST_DONE;
               end else begin
                  r_scan_idx <= r_scan_idx + 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready     = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign rsp_valid     = (r_state == ST_DONE);
   assign rsp_collision = r_collision;
   assign rsp_hit_index = r_hit_index;
   assign rsp_wall      = r_wall;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Scoreboard bench for collision_scan_ctrl: requests push expected responses, a monitor pops on rsp_valid.
module tb_collision_scan_ctrl;
   import collision_pkg::*;

   localparam int NUM_CARS = 8;
   localparam int IDX_W    = 3;
`ifdef BOUNDS_CHECK_EN
   localparam bit WALL_EN = 1'b1;
`else
   localparam bit WALL_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_index;
   logic [COORD_W-1:0] wr_x, wr_y;
   logic               wr_orient;
   logic               req_valid;
   logic               req_ready;
   logic [IDX_W-1:0]   req_index;
   logic [COORD_W-1:0] req_x, req_y;
   logic               req_orient;
   logic               rsp_valid;
   logic               rsp_collision;
   logic [IDX_W-1:0]   rsp_hit_index;
   logic               rsp_wall;
   logic               busy;

   collision_scan_ctrl #(.NUM_CARS(NUM_CARS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_index      (wr_index),
      .wr_x          (wr_x),
      .wr_y          (wr_y),
      .wr_orient     (wr_orient),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_index     (req_index),
      .req_x         (req_x),
      .req_y         (req_y),
      .req_orient    (req_orient),
      .rsp_valid     (rsp_valid),
      .rsp_collision (rsp_collision),
      .rsp_hit_index (rsp_hit_index),
      .rsp_wall      (rsp_wall),
      .busy          (busy)
   );

   typedef struct {
      logic             coll;
      logic [IDX_W-1:0] hit;
      logic             wall;
      int               cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every response pulse is matched against the oldest expectation.
   exp_t m_e;
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            m_e = sb_q.pop_front();
            check("rsp_collision", 32'(rsp_collision), 32'(m_e.coll));
            check("rsp_hit_index", 32'(rsp_hit_index), 32'(m_e.hit));
            check("rsp_wall",      32'(rsp_wall),      32'(m_e.wall));
            check("rsp_cycle",     32'(cyc),           32'(m_e.cyc));
         end
      end
   end

   task automatic wr_entry(input int idx, input int x, input int y, input logic o);
      wr_en     = 1'b1;
      wr_index  = IDX_W'(idx);
      wr_x      = COORD_W'(x);
      wr_y      = COORD_W'(y);
      wr_orient = o;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accept edge. n = accept-to-DONE edges.
   task automatic issue_req(input int idx, input int x, input int y, input logic o,
                            input bit push, input logic coll, input int hit,
                            input logic wall, input int n);
      int g = 0;
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
      req_valid  = 1'b1;
      req_index  = IDX_W'(idx);
      req_x      = COORD_W'(x);
      req_y      = COORD_W'(y);
      req_orient = o;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wr_en     = 1'b0;
      if (push) sb_q.push_back('{coll, IDX_W'(hit), wall, cyc + n});
   endtask

   task automatic wait_idle();
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (busy && g < 40);
      if (busy) check("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_req(input int idx, input int x, input int y, input logic o,
                         input logic coll, input int hit, input logic wall, input int n);
      issue_req(idx, x, y, o, 1'b1, coll, hit, wall, n);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_index = '0; wr_x = '0; wr_y = '0; wr_orient = 1'b0;
      req_valid = 1'b0; req_index = '0; req_x = '0; req_y = '0; req_orient = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_rsp_valid",     32'(rsp_valid),     32'd0);
      check("reset_rsp_collision", 32'(rsp_collision), 32'd0);
      check("reset_rsp_hit_index", 32'(rsp_hit_index), 32'd0);
      check("reset_rsp_wall",      32'(rsp_wall),      32'd0);
      check("reset_busy",          32'(busy),          32'd0);
      check("reset_req_ready",     32'(req_ready),     32'd1);

      // Empty table: full scan, commit car1.
      do_req(1, 10, 20, 1'b0, 1'b0, 0, 1'b0, NUM_CARS);
      // Vertical car0 overlaps the proposed spot: hit on entry 0.
      wr_entry(0, 10, 10, 1'b1);
      do_req(1, 10, 20, 1'b0, 1'b1, 0, 1'b0, 1);
      // Car1 still valid at (10,20): car3 misses car0 and hits car1.
      do_req(3, 25, 20, 1'b1, 1'b1, 1, 1'b0, 2);
      // Touching edge at x=20 is clean; car1 moves.
      do_req(1, 20, 20, 1'b0, 1'b0, 0, 1'b0, NUM_CARS);
      // Cars 2 and 5 both overlap: lowest index reported.
      wr_entry(2, 200, 200, 1'b0);
      wr_entry(5, 205, 205, 1'b0);
      do_req(6, 210, 200, 1'b0, 1'b1, 2, 1'b0, 3);
      // Write on the accept edge lands first and is seen by the scan.
      wr_en = 1'b1; wr_index = 3'd4; wr_x = 10'd500; wr_y = 10'd100; wr_orient = 1'b0;
      do_req(7, 505, 100, 1'b0, 1'b1, 4, 1'b0, 5);
      // Write during SCAN is dropped.
      issue_req(7, 300, 300, 1'b0, 1'b1, 1'b0, 0, 1'b0, NUM_CARS);
      wr_entry(6, 400, 400, 1'b0);
      wait_idle();
      do_req(3, 405, 405, 1'b0, 1'b0, 0, 1'b0, NUM_CARS);
      // Reset mid-scan: no response, all entries invalidated.
      issue_req(0, 500, 100, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_busy",      32'(busy),      32'd0);
      check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_req_ready", 32'(req_ready), 32'd1);
      check("post_reset_busy",      32'(busy),      32'd0);
      repeat (8) @(negedge clk);
      do_req(0, 405, 405, 1'b0, 1'b0, 0, 1'b0, NUM_CARS);
      // Field edge: wall rejection only when bounds checking is built in.
      do_req(3, 630, 470, 1'b0, 1'b0, 0, WALL_EN, NUM_CARS);
      if (WALL_EN)
         do_req(4, 625, 465, 1'b0, 1'b0, 0, 1'b1, NUM_CARS);
      else
         do_req(4, 625, 465, 1'b0, 1'b1, 3, 1'b0, 4);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
